// File: rtl/mem_word_seq.sv
// Sequencer between the EX/MEM register and a 16-bit data memory: word ops become
// two halfword beats with one stall cycle, halfword ops pass through in one cycle.
module mem_word_seq #(
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        dirty,
  input  logic        skip,
  input  logic        wr_req,
  input  logic        word,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_di,
  input  logic [15:0] mem_do,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic {IDLE, WORD2} state_t;

  state_t      state_q, state_d;
  logic [15:0] hi_q, hi_d;
  logic        valid;
  logic        misaligned;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    mem_wr     = 1'b0;
    mem_addr   = addr;
    mem_di     = 16'h0000;
    stall      = 1'b0;
    done       = 1'b0;
    rdata      = 32'h0000_0000;
    err        = 1'b0;
    valid      = req & ~dirty & ~skip;
    misaligned = CHECK_ALIGN && (word ? (addr[1:0] != 2'b00) : addr[0]);

    if (rst) begin
      state_d  = IDLE;
      hi_d     = 16'h0000;
      mem_addr = 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid) begin
            if (misaligned) begin
              err = 1'b1;
            end else if (!word) begin
              mem_wr = wr_req;
              mem_di = wr_req ? wdata[15:0] : 16'h0000;
              done   = 1'b1;
              rdata  = {{16{sgn & mem_do[15]}}, mem_do};
            end else begin
              // First beat of a word: lower-addressed halfword, captured for the second beat
              mem_addr = {addr[31:2], 2'b00};
              mem_wr   = wr_req;
              mem_di   = wr_req ? (BIG_ENDIAN ? wdata[31:16] : wdata[15:0]) : 16'h0000;
              stall    = 1'b1;
              hi_d     = mem_do;
              state_d  = WORD2;
            end
          end
        end
        WORD2: begin
          // Committed once beat 1 issued, so req/dirty/skip are not consulted here
          mem_addr = {addr[31:2], 2'b10};
          mem_wr   = wr_req;
          mem_di   = wr_req ? (BIG_ENDIAN ? wdata[15:0] : wdata[31:16]) : 16'h0000;
          done     = 1'b1;
          rdata    = BIG_ENDIAN ? {hi_q, mem_do} : {mem_do, hi_q};
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_mem_word_seq.sv
// Directed bench for mem_word_seq: a big-endian and a little-endian instance, each
// with its own halfword memory; load results are checked through a scoreboard queue.
module tb_mem_word_seq;

  logic        clk = 1'b0;
  logic        rst, req, dirty, skip, wr_req, word, sgn;
  logic [31:0] addr, wdata;

  logic        mem_wr_be, stall_be, done_be, err_be;
  logic [31:0] mem_addr_be, rdata_be;
  logic [15:0] mem_di_be, mem_do_be;
  logic        mem_wr_le, stall_le, done_le, err_le;
  logic [31:0] mem_addr_le, rdata_le;
  logic [15:0] mem_di_le, mem_do_le;

  logic [15:0] mem_be [0:1023];
  logic [15:0] mem_le [0:1023];

  logic [31:0] exp_be [$];
  logic [31:0] exp_le [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_word_seq #(.BIG_ENDIAN(1'b1), .CHECK_ALIGN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .req(req), .dirty(dirty), .skip(skip), .wr_req(wr_req),
    .word(word), .sgn(sgn), .addr(addr), .wdata(wdata), .mem_wr(mem_wr_be),
    .mem_addr(mem_addr_be), .mem_di(mem_di_be), .mem_do(mem_do_be), .stall(stall_be),
    .done(done_be), .rdata(rdata_be), .err(err_be)
  );

  mem_word_seq #(.BIG_ENDIAN(1'b0), .CHECK_ALIGN(1'b1)) dut_le (
    .clk(clk), .rst(rst), .req(req), .dirty(dirty), .skip(skip), .wr_req(wr_req),
    .word(word), .sgn(sgn), .addr(addr), .wdata(wdata), .mem_wr(mem_wr_le),
    .mem_addr(mem_addr_le), .mem_di(mem_di_le), .mem_do(mem_do_le), .stall(stall_le),
    .done(done_le), .rdata(rdata_le), .err(err_le)
  );

  // Halfword memories: asynchronous read, write on the rising edge
  assign mem_do_be = mem_be[mem_addr_be[10:1]];
  assign mem_do_le = mem_le[mem_addr_le[10:1]];

  always @(posedge clk) begin
    if (mem_wr_be) mem_be[mem_addr_be[10:1]] <= mem_di_be;
    if (mem_wr_le) mem_le[mem_addr_le[10:1]] <= mem_di_le;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic wd, input logic s,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr_req = w; word = wd; sgn = s; addr = a; wdata = d;
    dirty = 1'b0; skip = 1'b0;
  endtask

  // Checks control outputs of both instances and drains the scoreboard on load completion
  task automatic sample(input string tag, input logic es, input logic ed,
                        input logic ee, input logic ew);
    @(negedge clk);
    check({tag, ".stall"}, {31'd0, stall_be}, {31'd0, es});
    check({tag, ".done"},  {31'd0, done_be},  {31'd0, ed});
    check({tag, ".err"},   {31'd0, err_be},   {31'd0, ee});
    check({tag, ".wr"},    {31'd0, mem_wr_be}, {31'd0, ew});
    check({tag, ".le_ctl"}, {28'd0, stall_le, done_le, err_le, mem_wr_le},
          {28'd0, es, ed, ee, ew});
    if (!mem_wr_be) check({tag, ".di0"}, {16'd0, mem_di_be}, 32'd0);
    if (done_be && !wr_req) begin
      if (exp_be.size() == 0) check({tag, ".sb_be_empty"}, 32'd1, 32'd0);
      else check({tag, ".rdata_be"}, rdata_be, exp_be.pop_front());
    end
    if (done_le && !wr_req) begin
      if (exp_le.size() == 0) check({tag, ".sb_le_empty"}, 32'd1, 32'd0);
      else check({tag, ".rdata_le"}, rdata_le, exp_le.pop_front());
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic es, input logic ed,
                      input logic ee, input logic ew);
    sample(tag, es, ed, ee, ew);
    next();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1234_5678);
    sample("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.addr", mem_addr_be, 32'd0);
    check("reset.rdata", rdata_be, 32'd0);
    next();
    rst = 1'b0;

    // Word store, two beats with one stall cycle
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1234_5678);
    sample("st_w1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("st_w1.addr", mem_addr_be, 32'h100);
    check("st_w1.di_be", {16'd0, mem_di_be}, 32'h1234);
    check("st_w1.di_le", {16'd0, mem_di_le}, 32'h5678);
    next();
    sample("st_w2", 1'b0, 1'b1, 1'b0, 1'b1);
    check("st_w2.addr", mem_addr_be, 32'h102);
    check("st_w2.di_be", {16'd0, mem_di_be}, 32'h5678);
    next();
    check("mem_be_100", {16'd0, mem_be[10'h080]}, 32'h1234);
    check("mem_be_102", {16'd0, mem_be[10'h081]}, 32'h5678);
    check("mem_le_100", {16'd0, mem_le[10'h080]}, 32'h5678);

    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'hCAFE_F00D);
    step("st_w104a", 1'b1, 1'b0, 1'b0, 1'b1);
    step("st_w104b", 1'b0, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    exp_be.push_back(32'h1234_5678);
    exp_le.push_back(32'h1234_5678);
    step("ld_w1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ld_w2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Halfword stores and sign/zero-extended loads
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0A, 32'hFFFF_8001);
    step("st_h0a", 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h202, 32'h0000_7777);
    step("st_h202", 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0A, 32'h0);
    exp_be.push_back(32'hFFFF_8001);
    exp_le.push_back(32'hFFFF_8001);
    step("ld_h_sx", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0A, 32'h0);
    exp_be.push_back(32'h0000_8001);
    exp_le.push_back(32'h0000_8001);
    step("ld_h_zx", 1'b0, 1'b1, 1'b0, 1'b0);

    // Misaligned requests
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h1111_2222);
    step("mis_w", 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h103, 32'h1111_2222);
    step("mis_h", 1'b0, 1'b0, 1'b1, 1'b0);
    check("mis.mem", {16'd0, mem_be[10'h081]}, 32'h5678);

    // Bubbles and flushed ops
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
    dirty = 1'b1;
    step("dirty", 1'b0, 1'b0, 1'b0, 1'b0);
    dirty = 1'b0;
    skip  = 1'b1;
    step("skip", 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("blk.mem0", {16'd0, mem_be[10'h080]}, 32'h1234);
    check("blk.mem1", {16'd0, mem_be[10'h081]}, 32'h5678);

    // Reset asserted in the second beat of a word store
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'hAAAA_5555);
    step("rst_w1", 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    sample("rst_w2", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_w2.addr", mem_addr_be, 32'd0);
    check("rst_w2.rdata", rdata_be, 32'd0);
    next();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.mem200", {16'd0, mem_be[10'h100]}, 32'hAAAA);
    check("rst.mem202", {16'd0, mem_be[10'h101]}, 32'h7777);
    check("rst.mem200_le", {16'd0, mem_le[10'h100]}, 32'h5555);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    exp_be.push_back(32'hFFFF_AAAA);
    exp_le.push_back(32'h0000_5555);
    step("rst_ld", 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back word loads; dirty during beat 2 must be ignored
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    exp_be.push_back(32'h1234_5678);
    exp_le.push_back(32'h1234_5678);
    step("b2b_a1", 1'b1, 1'b0, 1'b0, 1'b0);
    step("b2b_a2", 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
    exp_be.push_back(32'hCAFE_F00D);
    exp_le.push_back(32'hCAFE_F00D);
    step("b2b_b1", 1'b1, 1'b0, 1'b0, 1'b0);
    dirty = 1'b1;
    sample("b2b_b2", 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b_b2.addr_le", mem_addr_le, 32'h106);
    next();

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("end_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("sb_be_drained", exp_be.size(), 32'd0);
    check("sb_le_drained", exp_le.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
